// File: rtl/alu_pkg.sv
// Shared constants for the iterative ALU: opcodes, FSM states
// and the divide-by-zero quotient.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_SLL   = 4'h3;
  localparam logic [3:0] OP_SLT   = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_SLTU  = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REMU  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } alu_state_e;

  localparam int MAX_LENGTH = 64;
  localparam logic [MAX_LENGTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/alu_muldiv_core.sv
// Bit-serial datapath shared by unsigned multiply (shift-add)
// and unsigned restoring division; one bit per step.
module alu_muldiv_core import alu_pkg::*; #(
  parameter int LENGTH = 32,
  parameter int SHW    = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              div_mode,
  input  logic              sel_hi,
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  output logic              last,
  output logic [LENGTH-1:0] result
);

  logic [SHW-1:0]      cnt_q;
  logic [2*LENGTH-1:0] acc_q, acc_d;
  logic [LENGTH-1:0]   sreg_q, sreg_d;
  logic [LENGTH-1:0]   opnd_q;
  logic [LENGTH:0]     sum;
  logic [LENGTH:0]     rem_sh;
  logic                geq;

  assign last = step && (cnt_q == SHW'(LENGTH-1));

  // Division keeps the partial remainder in the low half of acc.
  always_comb begin
    acc_d  = acc_q;
    sreg_d = sreg_q;
    sum    = {1'b0, acc_q[2*LENGTH-1:LENGTH]}
           + {1'b0, (sreg_q[0] ? opnd_q : {LENGTH{1'b0}})};
    rem_sh = {acc_q[LENGTH-1:0], sreg_q[LENGTH-1]};
    geq    = rem_sh >= {1'b0, opnd_q};
    if (div_mode) begin
      sreg_d = {sreg_q[LENGTH-2:0], geq};
      if (geq)
        acc_d = {{LENGTH{1'b0}}, rem_sh[LENGTH-1:0] - opnd_q};
      else
        acc_d = {{LENGTH{1'b0}}, rem_sh[LENGTH-1:0]};
    end else begin
      acc_d  = {sum, acc_q[LENGTH-1:1]};
      sreg_d = sreg_q >> 1;
    end
  end

  always_comb begin
    result = '0;
    if (div_mode) begin
      if (sel_hi)
        result = acc_d[LENGTH-1:0];
      else if (opnd_q == '0)
        result = DIV_BY_ZERO_Q[LENGTH-1:0];
      else
        result = sreg_d;
    end else begin
      result = sel_hi ? acc_d[2*LENGTH-1:LENGTH]
                      : acc_d[LENGTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sreg_q <= '0;
      opnd_q <= '0;
    end else if (start) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sreg_q <= a;
      opnd_q <= b;
    end else if (step) begin
      cnt_q  <= cnt_q + 1'b1;
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Non-pipelined ALU: simple ops finish in one cycle, multiply
// and divide iterate one bit per cycle in the shared core.
module iterative_alu import alu_pkg::*; #(
  parameter int LENGTH = 32,
  parameter int SHW    = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [LENGTH-1:0] i_a,
  input  logic [LENGTH-1:0] i_b,
  input  logic [3:0]        i_control,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [LENGTH-1:0] o_result,
  output logic              o_alu_zero
);

  alu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic              accept;
  logic              is_mul, is_div;
  logic              md_start, md_last, sel_hi;
  logic [LENGTH-1:0] md_result;
  logic [LENGTH-1:0] simple;
  logic [SHW-1:0]    shamt;

  assign shamt    = i_b[SHW-1:0];
  assign is_mul   = (i_control == OP_MUL) || (i_control == OP_MULHU);
  assign is_div   = (i_control == OP_DIVU) || (i_control == OP_REMU);
  assign sel_hi   = (op_q == OP_MULHU) || (op_q == OP_REMU);
  assign md_start = accept && (is_mul || is_div);
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);

  always_comb begin
    simple = '0;
    case (i_control)
      OP_ADD:  simple = i_a + i_b;
      OP_SUB:  simple = i_a - i_b;
      OP_SLL:  simple = i_a << shamt;
      OP_SLT:  simple = {{(LENGTH-1){1'b0}},
                         $signed(i_a) < $signed(i_b)};
      OP_XOR:  simple = i_a ^ i_b;
      OP_SRL:  simple = i_a >> shamt;
      OP_OR:   simple = i_a | i_b;
      OP_AND:  simple = i_a & i_b;
      OP_SRA:  simple = $unsigned($signed(i_a) >>> shamt);
      OP_SLTU: simple = {{(LENGTH-1){1'b0}}, i_a < i_b};
      default: simple = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          accept = 1'b1;
          unique case (1'b1)
            is_mul:  state_d = S_MUL;
            is_div:  state_d = S_DIV;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_MUL, S_DIV: if (md_last) state_d = S_DONE;
      S_DONE:       if (i_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      o_result   <= '0;
      o_alu_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= i_control;
      if (accept && !md_start) begin
        o_result   <= simple;
        o_alu_zero <= (simple == '0);
      end else if (md_last) begin
        o_result   <= md_result;
        o_alu_zero <= (md_result == '0);
      end
    end
  end

  alu_muldiv_core #(
    .LENGTH (LENGTH),
    .SHW    (SHW)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .step     ((state_q == S_MUL) || (state_q == S_DIV)),
    .div_mode (state_q == S_DIV),
    .sel_hi   (sel_hi),
    .a        (i_a),
    .b        (i_b),
    .last     (md_last),
    .result   (md_result)
  );

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu (LENGTH=32): arithmetic
// reference model, per-cycle compare process, directed + random ops.
module tb_iterative_alu;

  localparam int L = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [L-1:0] i_a = '0;
  logic [L-1:0] i_b = '0;
  logic [3:0]   i_control = '0;
  logic         o_ready, o_valid, o_alu_zero;
  logic [L-1:0] o_result;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           exp_cyc = 0;
  bit           pending = 1'b0;
  bit           chk_en = 1'b0;
  logic [L-1:0] exp_res = '0;

  iterative_alu #(.LENGTH(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_control  (i_control),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_alu_zero (o_alu_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got, logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [L-1:0] model(logic [L-1:0] a,
                                         logic [L-1:0] b,
                                         logic [3:0] op);
    logic [2*L-1:0] p;
    int unsigned sh;
    p  = {{L{1'b0}}, a} * {{L{1'b0}}, b};
    sh = int'(b % L);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[L-1:0];
      4'h3: return a << sh;
      4'h4: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h5: return a ^ b;
      4'h6: return a >> sh;
      4'h7: return a | b;
      4'h8: return a & b;
      4'h9: return $unsigned($signed(a) >>> sh);
      4'hA: return (a < b) ? 1 : 0;
      4'hB: return p[2*L-1:L];
      4'hC: return (b == 0) ? {L{1'b1}} : a / b;
      4'hD: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int latency(logic [3:0] op);
    return (op == 4'h2 || op == 4'hB || op == 4'hC || op == 4'hD)
           ? L + 1 : 1;
  endfunction

  // Per-cycle compare against the model's expected timing/result.
  initial begin
    forever begin
      @(posedge clk);
      if (pending && cyc >= exp_cyc && i_ready) pending = 1'b0;
      cyc++;
      #1;
      if (chk_en) begin
        if (pending) begin
          chk("o_ready_busy", o_ready, 0);
          chk("o_valid", o_valid, cyc >= exp_cyc);
          if (cyc >= exp_cyc) begin
            chk("o_result", o_result, exp_res);
            chk("o_alu_zero", o_alu_zero, exp_res == 0);
          end
        end else begin
          chk("o_ready_idle", o_ready, 1);
          chk("o_valid_idle", o_valid, 0);
        end
      end
    end
  end

  task automatic scramble();
    i_a       = $urandom;
    i_b       = $urandom;
    i_control = 4'($urandom);
    i_valid   = 1'($urandom);
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  // Called and returns at a negedge.
  task automatic run_op(logic [L-1:0] a, logic [L-1:0] b,
                        logic [3:0] op, int hold, bit has_lit,
                        logic [L-1:0] lit, int lit_lat);
    int n;
    i_a       = a;
    i_b       = b;
    i_control = op;
    i_valid   = 1'b1;
    i_ready   = (hold == 0);
    exp_res   = model(a, b, op);
    exp_cyc   = cyc + latency(op);
    pending   = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin
      scramble();
      @(negedge clk);
      n++;
    end
    if (!o_valid) begin
      chk("valid_timeout", o_valid, 1);
      do_reset();
      return;
    end
    if (has_lit) begin
      chk("lit_result", o_result, lit);
      chk("lit_latency", n + 1, lit_lat);
    end
    repeat (hold) begin
      scramble();
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    i_valid = 1'b0;
  endtask

  function automatic logic [L-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_result", o_result, 0);
    chk("rst_o_zero", o_alu_zero, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(32'h7FFF_FFFF, 1, 4'h0, 0, 1, 32'h8000_0000, 1);
    run_op(5, 5, 4'h1, 0, 1, 0, 1);
    run_op(32'hFFFF_FFFF, 2, 4'h2, 0, 1, 32'hFFFF_FFFE, 33);
    run_op(32'hFFFF_FFFF, 2, 4'hB, 0, 1, 1, 33);
    run_op(100, 7, 4'hC, 0, 1, 14, 33);
    run_op(100, 7, 4'hD, 0, 1, 2, 33);
    run_op(9, 0, 4'hC, 0, 1, 32'hFFFF_FFFF, 33);
    run_op(9, 0, 4'hD, 0, 1, 9, 33);
    run_op(32'h8000_0000, 32'h24, 4'h9, 0, 1, 32'hF800_0000, 1);
    run_op(32'hFFFF_FFFF, 1, 4'h4, 0, 1, 1, 1);
    run_op(32'hFFFF_FFFF, 1, 4'hA, 0, 1, 0, 1);
    run_op(32'h1234_5678, 3, 4'hE, 0, 1, 0, 1);
    run_op(32'h1234_5678, 3, 4'hF, 2, 1, 0, 1);
    run_op(100, 7, 4'hC, 5, 1, 14, 33);

    // Reset in the middle of a division.
    i_a = 100; i_b = 7; i_control = 4'hC;
    i_valid = 1'b1; i_ready = 1'b0;
    exp_res = 14; exp_cyc = cyc + L + 1; pending = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    pending = 1'b0;
    #1;
    chk("midrst_o_ready", o_ready, 1);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_result", o_result, 0);
    chk("midrst_o_zero", o_alu_zero, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    run_op(3, 4, 4'h0, 0, 1, 7, 1);
    run_op(1000, 10, 4'hC, 1, 1, 100, 33);

    for (int k = 0; k < 150; k++)
      run_op(pick(), pick(), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), 1'b0, '0, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
